// File: rtl/pipe_stall_ctrl_pkg.sv
// ISA field layout, opcode constants and FSM state type shared by the
// pipeline stall controller and its hazard detector.
package pipe_stall_ctrl_pkg;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 27;
  localparam int unsigned RD_HI    = 26;
  localparam int unsigned RD_LO    = 22;
  localparam int unsigned RS_HI    = 21;
  localparam int unsigned RS_LO    = 17;
  localparam int unsigned RT_HI    = 16;
  localparam int unsigned RT_LO    = 12;
  localparam int unsigned ALUOP_HI = 6;
  localparam int unsigned ALUOP_LO = 2;

  localparam logic [4:0] ALU_R     = 5'b00000;
  localparam logic [4:0] OP_LW     = 5'b01000;
  localparam logic [4:0] OP_SW     = 5'b01001;
  localparam logic [4:0] OP_BNE    = 5'b10001;
  localparam logic [4:0] OP_BLT    = 5'b10010;
  localparam logic [4:0] OP_JR     = 5'b10101;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [4:0] f_op(input logic [31:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[RT_HI:RT_LO];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] ir);
    return ir[ALUOP_HI:ALUOP_LO];
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use detector: flags an F/D instruction that reads the destination
// of a load currently sitting in D/X.
module hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  output logic        load_use
);

  logic [4:0] fd_op;
  logic [4:0] dx_rd;
  logic       reads_rt;
  logic       reads_rd;
  logic       dx_is_load;
  logic       unused_ir_bits;

  assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:0]};

  always_comb begin
    fd_op      = f_op(fd_ir);
    dx_rd      = f_rd(dx_ir);
    dx_is_load = (f_op(dx_ir) == OP_LW) && (dx_rd != '0);
    reads_rt   = (fd_op == ALU_R);
    // stores, compare-branches and jr carry a source operand in the rd slot
    reads_rd   = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                 (fd_op == OP_BLT) || (fd_op == OP_JR);
    load_use   = dx_is_load &&
                 ((f_rs(fd_ir) == dx_rd) ||
                  (reads_rt && (f_rt(fd_ir) == dx_rd)) ||
                  (reads_rd && (f_rd(fd_ir) == dx_rd)));
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline latch enable/flush control: load-use stalls, taken-branch
// flushes and a start/ready sequencer for the multicycle mul/div unit.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        branch_taken,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  output logic        pc_enable,
  output logic        fd_enable,
  output logic        dx_enable,
  output logic        xm_enable,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             load_use;
  logic             dx_is_mul;
  logic             dx_is_div;

  hazard_detect u_hazard_detect (
    .fd_ir    (fd_ir),
    .dx_ir    (dx_ir),
    .load_use (load_use)
  );

  always_comb begin
    dx_is_mul = (f_op(dx_ir) == ALU_R) && (f_aluop(dx_ir) == ALUOP_MUL);
    dx_is_div = (f_op(dx_ir) == ALU_R) && (f_aluop(dx_ir) == ALUOP_DIV);
  end

  always_comb begin
    pc_enable    = 1'b1;
    fd_enable    = 1'b1;
    dx_enable    = 1'b1;
    xm_enable    = 1'b1;
    fd_flush     = 1'b0;
    dx_flush     = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_error     = 1'b0;
    state_nx     = state;
    count_nx     = count;
    // while clrn is held low the decode is suppressed so no start pulse
    // can escape from whatever still sits in the latches
    if (clrn) begin
      case (state)
        IDLE: begin
          if (dx_is_mul || dx_is_div) begin
            md_ctrl_mult = dx_is_mul;
            md_ctrl_div  = dx_is_div;
            pc_enable    = 1'b0;
            fd_enable    = 1'b0;
            dx_enable    = 1'b0;
            xm_enable    = 1'b0;
            state_nx     = BUSY;
            count_nx     = '0;
          end else if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (load_use) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            dx_flush  = 1'b1;
          end
        end
        BUSY: begin
          if (md_result_rdy) begin
            md_error = md_exception;
            state_nx = IDLE;
            count_nx = '0;
          end else if (count == CNT_LAST) begin
            md_error = 1'b1;
            state_nx = IDLE;
            count_nx = '0;
          end else begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            dx_enable = 1'b0;
            xm_enable = 1'b0;
            count_nx  = (count == CNT_MAX) ? count : count + CNT_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: IDLE decode vector table plus
// multi-cycle mul/div, timeout and reset sequences, scoreboarded per cycle.
module tb_pipe_stall_ctrl;

  localparam int unsigned MD_TIMEOUT = 40;

  // output bundle order: {pc,fd,dx,xm enables, fd_flush, dx_flush, mult, div, error}
  localparam logic [8:0] E_RUN   = 9'b1111_00_000;
  localparam logic [8:0] E_STALL = 9'b0011_01_000;
  localparam logic [8:0] E_FLUSH = 9'b1111_11_000;
  localparam logic [8:0] E_HOLD  = 9'b0000_00_000;
  localparam logic [8:0] E_MUL   = 9'b0000_00_100;
  localparam logic [8:0] E_DIV   = 9'b0000_00_010;
  localparam logic [8:0] E_ERR   = 9'b1111_00_001;

  logic        clock;
  logic        clrn;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        branch_taken;
  logic        md_result_rdy;
  logic        md_exception;
  logic        pc_enable, fd_enable, dx_enable, xm_enable;
  logic        fd_flush, dx_flush, md_ctrl_mult, md_ctrl_div, md_error;

  pipe_stall_ctrl #(
    .MD_TIMEOUT (MD_TIMEOUT),
    .CNT_W      (6)
  ) dut (
    .clock         (clock),
    .clrn          (clrn),
    .fd_ir         (fd_ir),
    .dx_ir         (dx_ir),
    .branch_taken  (branch_taken),
    .md_result_rdy (md_result_rdy),
    .md_exception  (md_exception),
    .pc_enable     (pc_enable),
    .fd_enable     (fd_enable),
    .dx_enable     (dx_enable),
    .xm_enable     (xm_enable),
    .fd_flush      (fd_flush),
    .dx_flush      (dx_flush),
    .md_ctrl_mult  (md_ctrl_mult),
    .md_ctrl_div   (md_ctrl_div),
    .md_error      (md_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [8:0] exp;
    string      name;
  } exp_t;

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        br;
    logic [8:0]  exp;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   div_pulses = 0;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [8:0] got;
    got = {pc_enable, fd_enable, dx_enable, xm_enable, fd_flush, dx_flush,
           md_ctrl_mult, md_ctrl_div, md_error};
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty got=%b want=<entry>", got);
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", e.name, got, e.exp);
    end
    if (md_ctrl_div === 1'b1) div_pulses++;
  endtask

  task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                      input logic rdy, input logic exc, input logic rst_n_v,
                      input logic [8:0] exp, input string name);
    exp_t e;
    @(negedge clock);
    fd_ir         = fd;
    dx_ir         = dx;
    branch_taken  = br;
    md_result_rdy = rdy;
    md_exception  = exc;
    clrn          = rst_n_v;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    #2;
    check_out();
  endtask

  logic [31:0] mul_ir, div_ir, lw5, lw0;

  initial begin
    mul_ir = mk_r(5'd3, 5'd1, 5'd2, 5'b00110);
    div_ir = mk_r(5'd4, 5'd1, 5'd2, 5'b00111);
    lw5    = mk_i(5'b01000, 5'd5, 5'd1, 5'd0);
    lw0    = mk_i(5'b01000, 5'd0, 5'd1, 5'd0);

    vecs.push_back('{NOP, NOP, 1'b0, E_RUN, "idle_nop"});
    vecs.push_back('{mk_r(5'd6, 5'd5, 5'd2, 5'd1), lw5, 1'b0, E_STALL, "lu_rs"});
    vecs.push_back('{mk_r(5'd6, 5'd2, 5'd5, 5'd1), lw5, 1'b0, E_STALL, "lu_rt_rtype"});
    vecs.push_back('{mk_i(5'b00001, 5'd6, 5'd2, 5'd5), lw5, 1'b0, E_RUN, "no_lu_rt_itype"});
    vecs.push_back('{mk_r(5'd5, 5'd2, 5'd3, 5'd1), lw5, 1'b0, E_RUN, "no_lu_rd_rtype"});
    vecs.push_back('{mk_i(5'b01001, 5'd5, 5'd2, 5'd0), lw5, 1'b0, E_STALL, "lu_sw_rd"});
    vecs.push_back('{mk_i(5'b10001, 5'd5, 5'd2, 5'd0), lw5, 1'b0, E_STALL, "lu_bne_rd"});
    vecs.push_back('{mk_i(5'b10101, 5'd5, 5'd0, 5'd0), lw5, 1'b0, E_STALL, "lu_jr_rd"});
    vecs.push_back('{mk_r(5'd6, 5'd0, 5'd2, 5'd1), lw0, 1'b0, E_RUN, "no_lu_r0"});
    vecs.push_back('{mk_r(5'd6, 5'd5, 5'd2, 5'd1), lw5, 1'b1, E_FLUSH, "branch_over_lu"});
    vecs.push_back('{NOP, NOP, 1'b1, E_FLUSH, "branch_plain"});

    clrn = 1'b0; fd_ir = NOP; dx_ir = NOP;
    branch_taken = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0;

    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, "in_reset");
    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN, "after_reset");

    foreach (vecs[i])
      step(vecs[i].fd, vecs[i].dx, vecs[i].br, 1'b0, 1'b0, 1'b1, vecs[i].exp, vecs[i].name);

    // load-use followed by the bubble the flush inserted: exactly one stall
    step(mk_r(5'd6, 5'd5, 5'd2, 5'd1), lw5, 1'b0, 1'b0, 1'b0, 1'b1, E_STALL, "lu_once_a");
    step(mk_r(5'd6, 5'd5, 5'd2, 5'd1), NOP, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN, "lu_once_b");

    // mul, ready on the 17th BUSY cycle
    step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_MUL, "mul_pulse");
    for (int i = 0; i < 16; i++)
      step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_HOLD, "mul_busy");
    step(NOP, mul_ir, 1'b0, 1'b1, 1'b0, 1'b1, E_RUN, "mul_release");
    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN, "mul_after");

    // div with exception on ready
    div_pulses = 0;
    step(NOP, div_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_DIV, "div_pulse");
    for (int i = 0; i < 4; i++)
      step(NOP, div_ir, 1'b0, 1'b0, 1'b1, 1'b1, E_HOLD, "div_busy");
    step(NOP, div_ir, 1'b0, 1'b1, 1'b1, 1'b1, E_ERR, "div_exc_release");
    step(NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN, "div_err_cleared");
    total++;
    if (div_pulses != 1) begin
      bad++;
      $display("FAIL div_pulse_count got=%0d want=1", div_pulses);
    end

    // timeout: release MD_TIMEOUT cycles after the pulse with error
    step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_MUL, "to_pulse");
    for (int i = 1; i < MD_TIMEOUT; i++)
      step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_HOLD, "to_busy");
    step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_ERR, "to_release");
    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN, "to_after");

    // ready on the timeout cycle: ready wins, error follows exception
    step(NOP, div_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_DIV, "tor_pulse");
    for (int i = 1; i < MD_TIMEOUT; i++)
      step(NOP, div_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_HOLD, "tor_busy");
    step(NOP, div_ir, 1'b0, 1'b1, 1'b0, 1'b1, E_RUN, "tor_rdy_noexc");
    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN, "tor_after");

    // reset mid-BUSY at count 5
    step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_MUL, "rst_pulse");
    for (int i = 0; i < 5; i++)
      step(NOP, mul_ir, 1'b0, 1'b0, 1'b0, 1'b1, E_HOLD, "rst_busy");
    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN, "rst_mid_busy");
    step(NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, E_RUN, "rst_release_nop");
    step(mk_r(5'd6, 5'd5, 5'd2, 5'd1), lw5, 1'b0, 1'b0, 1'b0, 1'b1, E_STALL, "rst_idle_lu");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
